// File: rtl/core_fque_pkg.sv
// Shared types and constants for the free-pointer cache.
// Holds the control FSM encoding and the legal pop-latency values.
package core_fque_pkg;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        DRAIN = 2'd1,
        FLUSH = 2'd2,
        DONE  = 2'd3
    } fsm_t;

    localparam int POP_LAT_COMB = 0;
    localparam int POP_LAT_FLOP = 1;

endpackage

// File: rtl/core_fque_sfifo.sv
// Small synchronous FIFO with occupancy count and combinational head.
// Ports: wr_en/wr_data push, rd_en pop, head = oldest entry, cnt = occupancy.
module core_fque_sfifo #(
    parameter int W     = 5,
    parameter int DEPTH = 4,
    parameter int CW    = 3
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          wr_en,
    input  logic [W-1:0]  wr_data,
    input  logic          rd_en,
    output logic [W-1:0]  head,
    output logic [CW-1:0] cnt
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wp;
    logic [AW-1:0] rp;
    logic          full;
    logic          empty;
    logic          do_rd;
    logic          do_wr;

    assign full  = (cnt == CW'(DEPTH));
    assign empty = (cnt == '0);
    assign do_rd = rd_en && !empty;
    // A full FIFO still takes a write when the head leaves in the same cycle.
    assign do_wr = wr_en && (!full || do_rd);
    assign head  = mem[rp];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wp  <= '0;
            rp  <= '0;
            cnt <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (do_wr) begin
                mem[wp] <= wr_data;
                wp      <= wp + AW'(1);
            end
            if (do_rd) begin
                rp <= rp + AW'(1);
            end
            unique case ({do_wr, do_rd})
                2'b10:   cnt <= cnt + CW'(1);
                2'b01:   cnt <= cnt - CW'(1);
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/core_fque_ptr_cache.sv
// Client-side free-pointer cache: pops the queue to keep a local cache,
// grants allocations from it, returns freed pointers and flushes on request.
// Ports: fq_* queue side, alloc_* grant port, free_* return port,
// flush/flush_done control, cache_cnt occupancy, err_unexp sticky error.
import core_fque_pkg::*;

module core_fque_ptr_cache #(
    parameter int BITQPTR     = 5,
    parameter int BITQCNT     = 5,
    parameter int CACHE_DEPTH = 4,
    parameter int BITCCNT     = 3,
    parameter int RETQ_DEPTH  = 4,
    parameter int POP_LAT     = 0
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               fq_ready,
    input  logic [BITQCNT-1:0] fq_freecnt,
    output logic               fq_pop,
    input  logic               fq_po_pvld,
    input  logic [BITQPTR-1:0] fq_po_ptr,
    output logic               fq_push,
    output logic [BITQPTR-1:0] fq_pu_ptr,
    input  logic               alloc_req,
    output logic               alloc_gnt,
    output logic [BITQPTR-1:0] alloc_ptr,
    input  logic               free_vld,
    output logic               free_rdy,
    input  logic [BITQPTR-1:0] free_ptr,
    input  logic               flush,
    output logic               flush_done,
    output logic [BITCCNT-1:0] cache_cnt,
    output logic               err_unexp
);

    localparam int RCW = $clog2(RETQ_DEPTH + 1);
    localparam logic [BITCCNT:0] CD_EXT = (BITCCNT+1)'(CACHE_DEPTH);

    fsm_t               state;
    logic               up;
    logic               pop_d1;
    logic               err_q;
    logic               done_q;
    logic [BITCCNT-1:0] inflight;

    logic               c_wr;
    logic               c_rd;
    logic [BITQPTR-1:0] c_head;
    logic [BITCCNT-1:0] c_cnt;
    logic               c_empty;

    logic               r_wr;
    logic               r_rd;
    logic [BITQPTR-1:0] r_head;
    logic [RCW-1:0]     r_cnt;
    logic               r_empty;
    logic               r_full;

    logic [BITCCNT:0]   occ;
    logic               pop_now;
    logic               pvld_ok;
    logic               pvld_bad;
    logic               use_cache;
    logic               src_empty;

    assign c_empty = (c_cnt == '0);
    assign r_empty = (r_cnt == '0);
    assign r_full  = (r_cnt == RCW'(RETQ_DEPTH));

    // Outstanding pops count as occupied slots so the cache never overfills.
    assign occ = {1'b0, c_cnt} + {1'b0, inflight};

    // pop_d1 covers the cycle where the queue's freecnt is still stale.
    assign pop_now = up
                  && (state == RUN)
                  && fq_ready
                  && (occ < CD_EXT)
                  && (fq_freecnt > BITQCNT'(pop_d1));
    assign fq_pop = pop_now;

    // A combinational queue answers in the pop cycle itself.
    assign pvld_ok = fq_po_pvld
                  && ((inflight != '0)
                   || ((POP_LAT == POP_LAT_COMB) && pop_now));
    assign pvld_bad = fq_po_pvld && !pvld_ok;
    assign c_wr     = pvld_ok;

    assign alloc_gnt = alloc_req && !c_empty && (state == RUN);
    assign alloc_ptr = alloc_gnt ? c_head : '0;

    // During FLUSH the cache is drained only once retq is empty.
    assign use_cache = (state == FLUSH) && r_empty;
    assign src_empty = use_cache ? c_empty : r_empty;
    assign fq_push   = fq_ready && !src_empty;

    always_comb begin
        fq_pu_ptr = '0;
        unique case (1'b1)
            (fq_push && use_cache):  fq_pu_ptr = c_head;
            (fq_push && !use_cache): fq_pu_ptr = r_head;
            default:                 fq_pu_ptr = '0;
        endcase
    end

    assign r_rd = fq_push && !use_cache;
    assign c_rd = alloc_gnt || (fq_push && use_cache);

    assign free_rdy = up && !r_full;
    assign r_wr     = free_vld && free_rdy;

    assign cache_cnt  = c_cnt;
    assign err_unexp  = err_q;
    assign flush_done = done_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            up       <= 1'b0;
            pop_d1   <= 1'b0;
            err_q    <= 1'b0;
            inflight <= '0;
        end else begin
            up     <= 1'b1;
            pop_d1 <= pop_now;
            err_q  <= err_q | pvld_bad;
            unique case ({pop_now, pvld_ok})
                2'b10:   inflight <= inflight + BITCCNT'(1);
                2'b01:   inflight <= inflight - BITCCNT'(1);
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= RUN;
            done_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            unique case (state)
                RUN: begin
                    if (flush) begin
                        state <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (inflight == '0) begin
                        state <= FLUSH;
                    end
                end
                FLUSH: begin
                    if (c_empty && r_empty) begin
                        state  <= DONE;
                        done_q <= 1'b1;
                    end
                end
                DONE: begin
                    state <= RUN;
                end
                default: begin
                    state <= RUN;
                end
            endcase
        end
    end

    core_fque_sfifo #(
        .W     (BITQPTR),
        .DEPTH (CACHE_DEPTH),
        .CW    (BITCCNT)
    ) u_cache (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en   (c_wr),
        .wr_data (fq_po_ptr),
        .rd_en   (c_rd),
        .head    (c_head),
        .cnt     (c_cnt)
    );

    core_fque_sfifo #(
        .W     (BITQPTR),
        .DEPTH (RETQ_DEPTH),
        .CW    (RCW)
    ) u_retq (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en   (r_wr),
        .wr_data (free_ptr),
        .rd_en   (r_rd),
        .head    (r_head),
        .cnt     (r_cnt)
    );

endmodule

// File: tb/tb_core_fque_ptr_cache.sv
// Bench for core_fque_ptr_cache: a combinational-queue instance (a_*)
// and a flopped-queue instance (b_*) driven by tables, sequences, random.
module tb_core_fque_ptr_cache;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    localparam int M_RUN   = 0;
    localparam int M_DRAIN = 1;
    localparam int M_FLUSH = 2;
    localparam int M_DONE  = 3;

    logic       a_rst_n, a_ready, a_pop, a_pvld, a_push;
    logic       a_req, a_gnt, a_fvld, a_frdy, a_flush, a_done;
    logic       a_err, a_inj;
    logic [4:0] a_freecnt, a_ptr, a_pu, a_aptr, a_fptr, a_iptr;
    logic [4:0] a_next;
    logic [2:0] a_cnt;

    logic       b_rst_n, b_ready, b_pop, b_pvld, b_push;
    logic       b_req, b_gnt, b_fvld, b_frdy, b_flush, b_done, b_err;
    logic [4:0] b_freecnt, b_poptr, b_pu, b_aptr, b_fptr;
    logic [2:0] b_cnt;

    typedef struct {
        logic       req;
        logic       pop;
        logic       gnt;
        logic [4:0] ptr;
        logic [2:0] cnt;
    } vec_t;
    vec_t tbl [14];

    int got [$];
    int cq [$];
    int rq [$];
    int exp_fl [5];

    // Queue emulation for the combinational instance: answer every pop
    // in the same cycle with an incrementing pointer starting at 3.
    always @(posedge clk or negedge a_rst_n) begin
        if (!a_rst_n) a_next <= 5'd3;
        else if (a_pop) a_next <= a_next + 5'd1;
    end
    assign a_pvld = a_pop | a_inj;
    assign a_ptr  = a_inj ? a_iptr : a_next;

    core_fque_ptr_cache #(.POP_LAT(0)) u_a (
        .clk(clk), .rst_n(a_rst_n),
        .fq_ready(a_ready), .fq_freecnt(a_freecnt),
        .fq_pop(a_pop), .fq_po_pvld(a_pvld), .fq_po_ptr(a_ptr),
        .fq_push(a_push), .fq_pu_ptr(a_pu),
        .alloc_req(a_req), .alloc_gnt(a_gnt), .alloc_ptr(a_aptr),
        .free_vld(a_fvld), .free_rdy(a_frdy), .free_ptr(a_fptr),
        .flush(a_flush), .flush_done(a_done),
        .cache_cnt(a_cnt), .err_unexp(a_err)
    );

    core_fque_ptr_cache #(.POP_LAT(1)) u_b (
        .clk(clk), .rst_n(b_rst_n),
        .fq_ready(b_ready), .fq_freecnt(b_freecnt),
        .fq_pop(b_pop), .fq_po_pvld(b_pvld), .fq_po_ptr(b_poptr),
        .fq_push(b_push), .fq_pu_ptr(b_pu),
        .alloc_req(b_req), .alloc_gnt(b_gnt), .alloc_ptr(b_aptr),
        .free_vld(b_fvld), .free_rdy(b_frdy), .free_ptr(b_fptr),
        .flush(b_flush), .flush_done(b_done),
        .cache_cnt(b_cnt), .err_unexp(b_err)
    );

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d want %0d", nm, act, exp);
        end
    endtask

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    int  pops, dn, rf, ms, pd1;
    bit  e_pop, e_gnt, e_push, e_rdy, from_c, both_e;
    int  e_aptr, e_pu;

    initial begin
        a_rst_n = 0; a_ready = 1; a_freecnt = 16; a_req = 0;
        a_fvld = 0; a_fptr = 0; a_flush = 0; a_inj = 0; a_iptr = 0;
        b_rst_n = 0; b_ready = 1; b_freecnt = 1; b_req = 0;
        b_fvld = 0; b_fptr = 0; b_flush = 0; b_pvld = 0; b_poptr = 0;
        exp_fl = '{11, 2, 5, 9, 13};

        tbl[0]  = '{1'b0, 1'b1, 1'b0, 5'd0, 3'd0};
        tbl[1]  = '{1'b0, 1'b1, 1'b0, 5'd0, 3'd1};
        tbl[2]  = '{1'b0, 1'b1, 1'b0, 5'd0, 3'd2};
        tbl[3]  = '{1'b0, 1'b1, 1'b0, 5'd0, 3'd3};
        tbl[4]  = '{1'b0, 1'b0, 1'b0, 5'd0, 3'd4};
        tbl[5]  = '{1'b0, 1'b0, 1'b0, 5'd0, 3'd4};
        tbl[6]  = '{1'b1, 1'b0, 1'b1, 5'd3, 3'd4};
        tbl[7]  = '{1'b1, 1'b1, 1'b1, 5'd4, 3'd3};
        tbl[8]  = '{1'b1, 1'b1, 1'b1, 5'd5, 3'd3};
        tbl[9]  = '{1'b1, 1'b1, 1'b1, 5'd6, 3'd3};
        tbl[10] = '{1'b1, 1'b1, 1'b1, 5'd7, 3'd3};
        tbl[11] = '{1'b1, 1'b1, 1'b1, 5'd8, 3'd3};
        tbl[12] = '{1'b0, 1'b1, 1'b0, 5'd0, 3'd3};
        tbl[13] = '{1'b0, 1'b0, 1'b0, 5'd0, 3'd4};

        repeat (2) @(posedge clk);
        #1;
        chk("rst_pop", a_pop, 0);
        chk("rst_rdy", a_frdy, 0);
        chk("rst_cnt", a_cnt, 0);
        chk("rst_push", a_push, 0);
        chk("rst_done", a_done, 0);
        chk("rst_err", a_err, 0);
        nxt(); a_rst_n = 1; #1;
        chk("rel_rdy", a_frdy, 0);
        chk("rel_pop", a_pop, 0);

        // Initial fill, then allocation stream with refill.
        for (int i = 0; i < 14; i++) begin
            nxt(); a_req = tbl[i].req; #1;
            chk($sformatf("tbl%0d_pop", i), a_pop, tbl[i].pop);
            chk($sformatf("tbl%0d_gnt", i), a_gnt, tbl[i].gnt);
            chk($sformatf("tbl%0d_ptr", i), a_aptr, tbl[i].ptr);
            chk($sformatf("tbl%0d_cnt", i), a_cnt, tbl[i].cnt);
            chk($sformatf("tbl%0d_rdy", i), a_frdy, 1);
        end

        // Return FIFO fills while the queue is not ready.
        for (int i = 0; i < 6; i++) begin
            nxt(); a_req = 0; a_ready = 0;
            a_fvld = 1; a_fptr = 5'(20 + i); #1;
            chk($sformatf("ret_rdy%0d", i), a_frdy, (i < 4));
        end
        got.delete();
        for (int i = 0; i < 8; i++) begin
            nxt(); a_fvld = 0; a_ready = 1; #1;
            if (a_push) got.push_back(int'(a_pu));
        end
        chk("ret_n", got.size(), 4);
        for (int i = 0; i < 4 && i < got.size(); i++)
            chk($sformatf("ret_ord%0d", i), got[i], 20 + i);

        // Unexpected response with nothing outstanding.
        nxt(); a_inj = 1; a_iptr = 5'd30; #1;
        chk("inj_pop", a_pop, 0);
        nxt(); a_inj = 0; #1;
        chk("err_set", a_err, 1);
        chk("err_cnt", a_cnt, 4);
        for (int i = 0; i < 3; i++) begin
            nxt(); #1;
            chk("err_stk", a_err, 1);
        end
        a_rst_n = 0; #1;
        chk("err_rst", a_err, 0);
        chk("err_rcnt", a_cnt, 0);
        nxt(); a_rst_n = 1;

        // Random traffic against a queue-level model.
        cq.delete(); rq.delete(); ms = M_RUN; pd1 = 0;
        for (int n = 0; n < 600; n++) begin
            nxt();
            a_ready   = ($urandom_range(0, 7) != 0);
            a_freecnt = 5'($urandom_range(0, 16));
            a_req     = 1'($urandom_range(0, 1));
            a_fvld    = ($urandom_range(0, 2) == 0);
            a_fptr    = 5'($urandom);
            a_flush   = ($urandom_range(0, 39) == 0);
            #1;
            e_pop  = (ms == M_RUN) && a_ready && (cq.size() < 4)
                  && (int'(a_freecnt) > pd1);
            e_gnt  = a_req && (cq.size() > 0) && (ms == M_RUN);
            e_aptr = e_gnt ? cq[0] : 0;
            from_c = (ms == M_FLUSH) && (rq.size() == 0);
            e_push = a_ready && (from_c ? cq.size() > 0 : rq.size() > 0);
            e_pu   = !e_push ? 0 : (from_c ? cq[0] : rq[0]);
            e_rdy  = rq.size() < 4;
            both_e = (cq.size() == 0) && (rq.size() == 0);
            chk("r_pop", a_pop, e_pop);
            chk("r_gnt", a_gnt, e_gnt);
            chk("r_aptr", a_aptr, e_aptr);
            chk("r_push", a_push, e_push);
            chk("r_pu", a_pu, e_pu);
            chk("r_rdy", a_frdy, e_rdy);
            chk("r_cnt", a_cnt, cq.size());
            chk("r_done", a_done, (ms == M_DONE));
            chk("r_err", a_err, 0);
            if (e_push && from_c) void'(cq.pop_front());
            else if (e_push) void'(rq.pop_front());
            if (e_gnt) void'(cq.pop_front());
            if (e_pop) cq.push_back(int'(a_ptr));
            if (a_fvld && e_rdy) rq.push_back(int'(a_fptr));
            case (ms)
                M_RUN:   if (a_flush) ms = M_DRAIN;
                M_DRAIN: ms = M_FLUSH;
                M_FLUSH: if (both_e) ms = M_DONE;
                default: ms = M_RUN;
            endcase
            pd1 = e_pop;
        end
        nxt(); a_flush = 0; a_fvld = 0; a_req = 0;

        // Flopped queue: freecnt of 1 must yield a single pop.
        nxt(); b_rst_n = 1;
        pops = 0;
        for (int k = 0; k < 6; k++) begin
            nxt();
            b_freecnt = (k >= 2) ? 5'd0 : 5'd1;
            b_pvld = (k == 1); b_poptr = 5'd3; #1;
            if (k == 0) chk("ovr_first", b_pop, 1);
            if (b_pop) pops++;
        end
        chk("ovr_pops", pops, 1);
        chk("ovr_cnt", b_cnt, 1);
        chk("ovr_err", b_err, 0);

        // Flush with cached, returned and in-flight pointers.
        b_rst_n = 0; #1;
        nxt(); b_freecnt = 16; b_rst_n = 1;
        nxt(); #1;
        chk("fl_pop0", b_pop, 1);
        for (int k = 0; k < 3; k++) begin
            nxt(); b_pvld = 1;
            b_poptr = (k == 0) ? 5'd2 : (k == 1) ? 5'd5 : 5'd9; #1;
        end
        nxt(); b_pvld = 0; b_ready = 0; b_fvld = 1; b_fptr = 5'd11; #1;
        chk("fl_full_pop", b_pop, 0);
        chk("fl_cnt3", b_cnt, 3);
        chk("fl_rdy", b_frdy, 1);
        nxt(); b_fvld = 0; b_flush = 1;
        nxt(); b_flush = 0; b_pvld = 1; b_poptr = 5'd13; b_req = 1; #1;
        chk("drn_gnt", b_gnt, 0);
        chk("drn_pop", b_pop, 0);
        nxt(); b_pvld = 0; b_req = 0; #1;
        chk("drn_cnt", b_cnt, 4);
        got.delete(); dn = 0; rf = 0;
        for (int i = 0; i < 14; i++) begin
            nxt(); b_ready = 1; #1;
            if (b_push) got.push_back(int'(b_pu));
            if (b_done) dn++;
            if (dn > 0 && b_pop && !b_done) rf = 1;
        end
        chk("fl_n", got.size(), 5);
        for (int i = 0; i < 5 && i < got.size(); i++)
            chk($sformatf("fl_ord%0d", i), got[i], exp_fl[i]);
        chk("fl_done", dn, 1);
        chk("fl_refill", rf, 1);
        chk("fl_err", b_err, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
